// File: rtl/iomem_cmd_master_if.sv
// Signal bundle for iomem_cmd_master: command byte stream in, response byte stream out,
// and the PicoSoC iomem initiator bus.
interface iomem_cmd_master_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;

    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;

    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        input  in_valid, in_data, out_ready, iomem_ready, iomem_rdata,
        output in_ready, out_valid, out_data,
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata
    );

    modport slave (
        output in_valid, in_data, out_ready, iomem_ready, iomem_rdata,
        input  in_ready, out_valid, out_data,
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata
    );
endinterface

// File: rtl/iomem_cmd_master.sv
// Byte-stream command interpreter that runs single 32-bit read/write transactions
// on the PicoSoC iomem bus and streams the result back.
module iomem_cmd_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               resetn,
    iomem_cmd_master_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        STRB,
        WDATA,
        BUS,
        RESP
    } state_e;

    localparam int unsigned      CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    localparam logic [7:0] OP_WRITE  = 8'h57;
    localparam logic [7:0] OP_READ   = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_UNK   = 8'h3F;
    localparam logic [7:0] RSP_TIMEO = 8'h54;

    state_e           state_q,    state_d;
    logic [31:0]      addr_q,     addr_d;
    logic [31:0]      wdata_q,    wdata_d;
    logic [3:0]       wstrb_q,    wstrb_d;
    logic             isWrite_q,  isWrite_d;
    logic [1:0]       byteCnt_q,  byteCnt_d;
    logic             busValid_q, busValid_d;
    logic [CNT_W-1:0] toCnt_q,    toCnt_d;
    logic             outValid_q, outValid_d;
    logic [7:0]       outData_q,  outData_d;
    logic [23:0]      respBuf_q,  respBuf_d;
    logic [1:0]       respLeft_q, respLeft_d;

    logic inReady;
    logic inFire;

    assign inReady = resetn && (state_q inside {IDLE, ADDR, STRB, WDATA});
    assign inFire  = inReady && bus.in_valid;

    assign bus.in_ready    = inReady;
    assign bus.out_valid   = outValid_q;
    assign bus.out_data    = outData_q;
    assign bus.iomem_valid = busValid_q;
    assign bus.iomem_addr  = addr_q;
    assign bus.iomem_wdata = wdata_q;
    assign bus.iomem_wstrb = wstrb_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        isWrite_d  = isWrite_q;
        byteCnt_d  = byteCnt_q;
        busValid_d = busValid_q;
        toCnt_d    = toCnt_q;
        outValid_d = outValid_q;
        outData_d  = outData_q;
        respBuf_d  = respBuf_q;
        respLeft_d = respLeft_q;

        case (state_q)
            IDLE: begin
                if (inFire) begin
                    byteCnt_d = 2'd0;
                    if (bus.in_data == OP_WRITE) begin
                        isWrite_d = 1'b1;
                        state_d   = ADDR;
                    end else if (bus.in_data == OP_READ) begin
                        isWrite_d = 1'b0;
                        wstrb_d   = 4'h0;
                        state_d   = ADDR;
                    end else begin
                        outValid_d = 1'b1;
                        outData_d  = RSP_UNK;
                        respLeft_d = 2'd0;
                        state_d    = RESP;
                    end
                end
            end

            ADDR: begin
                if (inFire) begin
                    addr_d    = {addr_q[23:0], bus.in_data};
                    byteCnt_d = byteCnt_q + 2'd1;
                    if (byteCnt_q == 2'd3) begin
                        if (isWrite_q) begin
                            state_d = STRB;
                        end else begin
                            busValid_d = 1'b1;
                            toCnt_d    = '0;
                            state_d    = BUS;
                        end
                    end
                end
            end

            STRB: begin
                if (inFire) begin
                    wstrb_d   = bus.in_data[3:0];
                    byteCnt_d = 2'd0;
                    state_d   = WDATA;
                end
            end

            WDATA: begin
                if (inFire) begin
                    wdata_d   = {wdata_q[23:0], bus.in_data};
                    byteCnt_d = byteCnt_q + 2'd1;
                    if (byteCnt_q == 2'd3) begin
                        busValid_d = 1'b1;
                        toCnt_d    = '0;
                        state_d    = BUS;
                    end
                end
            end

            BUS: begin
                // Ready is checked first so a completion on the terminal count still wins.
                if (bus.iomem_ready) begin
                    busValid_d = 1'b0;
                    outValid_d = 1'b1;
                    state_d    = RESP;
                    if (isWrite_q) begin
                        outData_d  = RSP_OK;
                        respLeft_d = 2'd0;
                    end else begin
                        outData_d  = bus.iomem_rdata[31:24];
                        respBuf_d  = bus.iomem_rdata[23:0];
                        respLeft_d = 2'd3;
                    end
                end else if ((TIMEOUT != 0) && (toCnt_q == CNT_LAST)) begin
                    busValid_d = 1'b0;
                    outValid_d = 1'b1;
                    outData_d  = RSP_TIMEO;
                    respLeft_d = 2'd0;
                    state_d    = RESP;
                end else begin
                    toCnt_d = toCnt_q + 1'b1;
                end
            end

            RESP: begin
                if (bus.out_ready) begin
                    if (respLeft_q == 2'd0) begin
                        outValid_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        outData_d  = respBuf_q[23:16];
                        respBuf_d  = {respBuf_q[15:0], 8'h00};
                        respLeft_d = respLeft_q - 2'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            isWrite_q  <= 1'b0;
            byteCnt_q  <= '0;
            busValid_q <= 1'b0;
            toCnt_q    <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            respBuf_q  <= '0;
            respLeft_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            isWrite_q  <= isWrite_d;
            byteCnt_q  <= byteCnt_d;
            busValid_q <= busValid_d;
            toCnt_q    <= toCnt_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            respBuf_q  <= respBuf_d;
            respLeft_q <= respLeft_d;
        end
    end

endmodule

// File: tb/tb_iomem_cmd_master.sv
// Directed bench for iomem_cmd_master: GPIO responder model at 0x03000000,
// response byte monitor, and hand-computed expectations.
module tb_iomem_cmd_master;

    logic clk;
    logic resetn;

    iomem_cmd_master_if busIf ();

    iomem_cmd_master #(.TIMEOUT(16)) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (busIf)
    );

    int          testsRun  = 0;
    int          failCount = 0;
    int          cycle     = 0;

    logic [31:0] gpio        = 32'h0;
    bit          respEn      = 1'b0;
    bit          seenValid   = 1'b0;
    int          busCycles   = 0;
    int          validCycles = 0;
    int          stabErr     = 0;
    logic [31:0] lastAddr    = 32'h0;
    logic [31:0] lastWdata   = 32'h0;
    logic [3:0]  lastWstrb   = 4'h0;
    logic        prevValid   = 1'b0;
    logic [67:0] heldBus     = 68'h0;

    logic [7:0]  respQ[$];
    int          respCyc[$];
    int          acceptCycle;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Responder: raises ready on the second cycle of a request, like a registered peripheral.
    always @(negedge clk) begin
        busIf.iomem_ready = 1'b0;
        if (!resetn) begin
            seenValid = 1'b0;
            prevValid = 1'b0;
        end else begin
            if (busIf.iomem_valid) begin
                validCycles++;
                if (prevValid && heldBus !== {busIf.iomem_addr, busIf.iomem_wdata, busIf.iomem_wstrb})
                    stabErr++;
                heldBus = {busIf.iomem_addr, busIf.iomem_wdata, busIf.iomem_wstrb};
                if (respEn) begin
                    if (seenValid) begin
                        busIf.iomem_ready = 1'b1;
                        busCycles++;
                        lastAddr  = busIf.iomem_addr;
                        lastWdata = busIf.iomem_wdata;
                        lastWstrb = busIf.iomem_wstrb;
                        if (busIf.iomem_addr == 32'h0300_0000) begin
                            for (int b = 0; b < 4; b++)
                                if (busIf.iomem_wstrb[b])
                                    gpio[b*8 +: 8] = busIf.iomem_wdata[b*8 +: 8];
                            busIf.iomem_rdata = gpio;
                        end else begin
                            busIf.iomem_rdata = 32'h0;
                        end
                        seenValid = 1'b0;
                    end else begin
                        seenValid = 1'b1;
                    end
                end
            end else begin
                seenValid = 1'b0;
            end
            prevValid = busIf.iomem_valid;
        end
    end

    // Records each response byte together with the edge at which it transfers.
    always @(negedge clk) begin
        #1;
        if (resetn && busIf.out_valid && busIf.out_ready) begin
            respQ.push_back(busIf.out_data);
            respCyc.push_back(cycle + 1);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        int guard = 0;
        busIf.in_valid = 1'b1;
        busIf.in_data  = b;
        while (!busIf.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) checkOutput("in_ready timeout", 32'(guard), 32'd0);
        @(negedge clk);
        busIf.in_valid = 1'b0;
        acceptCycle    = cycle;
    endtask

    task automatic sendRead(input logic [31:0] addr);
        applyStimulus(8'h52);
        for (int i = 3; i >= 0; i--) applyStimulus(addr[i*8 +: 8]);
    endtask

    task automatic sendWrite(input logic [31:0] addr, input logic [7:0] strb, input logic [31:0] data);
        applyStimulus(8'h57);
        for (int i = 3; i >= 0; i--) applyStimulus(addr[i*8 +: 8]);
        applyStimulus(strb);
        for (int i = 3; i >= 0; i--) applyStimulus(data[i*8 +: 8]);
    endtask

    task automatic waitResponse(input int n);
        int guard = 0;
        while (respQ.size() < n && guard < 300) begin
            @(negedge clk);
            #2;
            guard++;
        end
        checkOutput("response count", 32'(respQ.size()), 32'(n));
        @(negedge clk);
    endtask

    function automatic logic [31:0] respWord();
        if (respQ.size() < 4) return 32'hxxxx_xxxx;
        return {respQ[0], respQ[1], respQ[2], respQ[3]};
    endfunction

    initial begin
        int       guard;
        int       bc;
        bit       dataMoved;
        bit       readyLeak;
        busIf.in_valid    = 1'b0;
        busIf.in_data     = 8'h00;
        busIf.out_ready   = 1'b1;
        busIf.iomem_ready = 1'b0;
        busIf.iomem_rdata = 32'h0;
        resetn            = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset iomem_valid", {31'd0, busIf.iomem_valid}, 32'd0);
        checkOutput("reset out_valid",   {31'd0, busIf.out_valid},   32'd0);
        checkOutput("reset in_ready",    {31'd0, busIf.in_ready},    32'd0);
        checkOutput("reset wstrb",       {28'd0, busIf.iomem_wstrb}, 32'd0);
        checkOutput("reset addr",        busIf.iomem_addr,           32'd0);
        checkOutput("reset wdata",       busIf.iomem_wdata,          32'd0);
        checkOutput("reset out_data",    {24'd0, busIf.out_data},    32'd0);
        resetn = 1'b1;
        respEn = 1'b1;
        @(negedge clk);
        checkOutput("idle in_ready", {31'd0, busIf.in_ready}, 32'd1);

        // Full write to GPIO
        respQ.delete(); respCyc.delete();
        sendWrite(32'h0300_0000, 8'h0F, 32'h1234_5678);
        checkOutput("write valid at N+1", {31'd0, busIf.iomem_valid}, 32'd1);
        waitResponse(1);
        checkOutput("write resp", {24'd0, respQ[0]}, 32'h4B);
        checkOutput("write resp edge", 32'(respCyc[0] - acceptCycle), 32'd3);
        checkOutput("write bus cycles", 32'(busCycles), 32'd1);
        checkOutput("write addr", lastAddr, 32'h0300_0000);
        checkOutput("write wstrb", {28'd0, lastWstrb}, 32'hF);
        checkOutput("write wdata", lastWdata, 32'h1234_5678);
        checkOutput("gpio after write", gpio, 32'h1234_5678);
        checkOutput("in_ready after K", {31'd0, busIf.in_ready}, 32'd1);

        // Read back
        respQ.delete(); respCyc.delete();
        sendRead(32'h0300_0000);
        waitResponse(4);
        checkOutput("read data", respWord(), 32'h1234_5678);
        checkOutput("read first edge", 32'(respCyc[0] - acceptCycle), 32'd3);
        checkOutput("read last edge", 32'(respCyc[3] - acceptCycle), 32'd6);
        checkOutput("read wstrb", {28'd0, lastWstrb}, 32'h0);
        checkOutput("read bus cycles", 32'(busCycles), 32'd2);
        checkOutput("in_ready after read", {31'd0, busIf.in_ready}, 32'd1);

        // Partial write of byte lane 1, then read back
        respQ.delete(); respCyc.delete();
        sendWrite(32'h0300_0000, 8'h02, 32'hAABB_CCDD);
        waitResponse(1);
        checkOutput("partial write resp", {24'd0, respQ[0]}, 32'h4B);
        checkOutput("partial wstrb", {28'd0, lastWstrb}, 32'h2);
        respQ.delete(); respCyc.delete();
        sendRead(32'h0300_0000);
        waitResponse(4);
        checkOutput("partial read data", respWord(), 32'h1234_CC78);

        // Timeout with no responder
        respEn = 1'b0;
        validCycles = 0;
        bc = busCycles;
        respQ.delete(); respCyc.delete();
        sendRead(32'h0400_0000);
        waitResponse(1);
        checkOutput("timeout resp", {24'd0, respQ[0]}, 32'h54);
        checkOutput("timeout valid cycles", 32'(validCycles), 32'd16);
        checkOutput("timeout resp edge", 32'(respCyc[0] - acceptCycle), 32'd17);
        checkOutput("timeout no bus cycle", 32'(busCycles), 32'(bc));
        respEn = 1'b1;
        respQ.delete(); respCyc.delete();
        sendRead(32'h0300_0000);
        waitResponse(4);
        checkOutput("read after timeout", respWord(), 32'h1234_CC78);

        // Unknown opcode
        bc = busCycles;
        respQ.delete(); respCyc.delete();
        applyStimulus(8'h41);
        checkOutput("unknown out_valid N+1", {31'd0, busIf.out_valid}, 32'd1);
        checkOutput("unknown out_data N+1", {24'd0, busIf.out_data}, 32'h3F);
        waitResponse(1);
        checkOutput("unknown resp", {24'd0, respQ[0]}, 32'h3F);
        checkOutput("unknown no bus cycle", 32'(busCycles), 32'(bc));
        respQ.delete(); respCyc.delete();
        sendRead(32'h0300_0000);
        waitResponse(4);
        checkOutput("read after unknown", respWord(), 32'h1234_CC78);

        // Backpressure on the read response
        respQ.delete(); respCyc.delete();
        busIf.out_ready = 1'b0;
        sendRead(32'h0300_0000);
        guard = 0;
        while (!busIf.out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("bp out_valid", {31'd0, busIf.out_valid}, 32'd1);
        dataMoved = 1'b0;
        readyLeak = 1'b0;
        repeat (5) begin
            if (busIf.out_data !== 8'h12 || !busIf.out_valid) dataMoved = 1'b1;
            if (busIf.in_ready) readyLeak = 1'b1;
            @(negedge clk);
        end
        checkOutput("bp data held", {31'd0, dataMoved}, 32'd0);
        checkOutput("bp in_ready low", {31'd0, readyLeak}, 32'd0);
        busIf.out_ready = 1'b1;
        waitResponse(4);
        checkOutput("bp read data", respWord(), 32'h1234_CC78);
        repeat (5) @(negedge clk);
        checkOutput("bp no duplicates", 32'(respQ.size()), 32'd4);

        // Reset while a transaction is stalled
        respEn = 1'b0;
        respQ.delete(); respCyc.delete();
        sendRead(32'h0300_0000);
        repeat (3) @(negedge clk);
        checkOutput("stall valid", {31'd0, busIf.iomem_valid}, 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        checkOutput("mid reset iomem_valid", {31'd0, busIf.iomem_valid}, 32'd0);
        checkOutput("mid reset out_valid", {31'd0, busIf.out_valid}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        respEn = 1'b1;
        repeat (25) @(negedge clk);
        checkOutput("no resp after reset", 32'(respQ.size()), 32'd0);
        sendWrite(32'h0300_0000, 8'h0F, 32'hCAFE_F00D);
        waitResponse(1);
        checkOutput("post reset write resp", {24'd0, respQ[0]}, 32'h4B);
        checkOutput("post reset gpio", gpio, 32'hCAFE_F00D);

        checkOutput("bus stable while valid", 32'(stabErr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
